// File: rtl/pipe_addsub.sv
// Elastic pipelined adder/subtractor with per-stage valid bits and bubble collapse.
// Define PIPE_ADDSUB_SAT_EN to clamp overflowing results instead of wrapping them.
module pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             ovf,
    output logic [3:0]       count
);

`ifdef PIPE_ADDSUB_SAT_EN
    function automatic logic signed [WIDTH-1:0] sat_clamp(
        input logic [WIDTH-1:0] val,
        input logic             ovf_in,
        input logic             a_sign
    );
        if (!ovf_in) return val;
        return a_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    logic [WIDTH-1:0] b_eff_p0;
    logic [WIDTH:0]   sum_p0;
    logic [WIDTH-1:0] res_p0;
    logic             cy_p0;
    logic             ovf_p0;

    logic [WIDTH-1:0] res_p [1:STAGES];
    logic [STAGES:1]  cy_p;
    logic [STAGES:1]  ovf_p;
    logic [STAGES:1]  vld_p;
    logic [STAGES:1]  ld;

    // Stage 0: combinational add/sub and signed-overflow detection
    always_comb begin
        b_eff_p0 = sub ? ~b : b;
        sum_p0   = {1'b0, a} + {1'b0, b_eff_p0} + {{WIDTH{1'b0}}, sub};
        cy_p0    = sum_p0[WIDTH];
        ovf_p0   = (a[WIDTH-1] == b_eff_p0[WIDTH-1]) && (sum_p0[WIDTH-1] != a[WIDTH-1]);
`ifdef PIPE_ADDSUB_SAT_EN
        res_p0   = sat_clamp(sum_p0[WIDTH-1:0], ovf_p0, a[WIDTH-1]);
`else
        res_p0   = sum_p0[WIDTH-1:0];
`endif
    end

    // A stage may load if it is empty or everything downstream of it can advance.
    always_comb begin : load_chain
        logic nxt;
        nxt = out_ready;
        ld  = '0;
        for (int i = STAGES; i >= 1; i--) begin
            nxt   = !vld_p[i] || nxt;
            ld[i] = nxt;
        end
    end

    assign in_ready = rst_n && ld[1];

    // Stages 1..STAGES: result registers and valid bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p <= '0;
            cy_p  <= '0;
            ovf_p <= '0;
            for (int i = 1; i <= STAGES; i++) begin
                res_p[i] <= '0;
            end
        end else begin
            if (ld[1]) begin
                vld_p[1] <= in_valid;
                res_p[1] <= res_p0;
                cy_p[1]  <= cy_p0;
                ovf_p[1] <= ovf_p0;
            end
            for (int i = 2; i <= STAGES; i++) begin
                if (ld[i]) begin
                    vld_p[i] <= vld_p[i-1];
                    res_p[i] <= res_p[i-1];
                    cy_p[i]  <= cy_p[i-1];
                    ovf_p[i] <= ovf_p[i-1];
                end
            end
        end
    end

    always_comb begin
        count = '0;
        for (int i = 1; i <= STAGES; i++) begin
            count = count + 4'(vld_p[i]);
        end
    end

    assign out_valid = vld_p[STAGES];
    assign out       = res_p[STAGES];
    assign carry     = cy_p[STAGES];
    assign ovf       = ovf_p[STAGES];

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and result width in bits, legal range 2..64.
REQ-002 SHALL have parameter STAGES, default 3: pipeline register stages, legal range 1..8.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have port in_valid, input, 1: operands and mode valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts the operands this cycle.
REQ-007 SHALL have ports a and b, input, WIDTH each: operands.
REQ-008 SHALL have port sub, input, 1: 0 gives a+b, 1 gives a-b.
REQ-009 SHALL have port out_valid, output, 1: result valid.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have port out, output, WIDTH: result.
REQ-012 SHALL have port carry, output, 1: unsigned carry-out (add) or not-borrow (sub).
REQ-013 SHALL have port ovf, output, 1: two's-complement signed overflow.
REQ-014 SHALL have port count, output, 4: number of results currently held in the pipeline.

Function
REQ-015 Input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; output transfer SHALL occur where out_valid=1 and out_ready=1.
REQ-016 Arithmetic SHALL use {1'b0,a} + {1'b0,b} for add and {1'b0,a} + {1'b0,~b} + 1 for sub; out = low WIDTH bits, carry = bit WIDTH, computed before the first stage register.
REQ-017 ovf SHALL be 1 when a and the effective b (b for add, ~b for sub) share a sign bit that differs from the sign bit of out.
REQ-018 Each stage SHALL hold a valid bit plus {out, carry, ovf}; stage 1 loads from the adder and stage i loads from stage i-1.
REQ-019 Stage i SHALL load when it is empty or when its contents move forward in the same cycle; the last stage moves forward on an output transfer.
REQ-020 Bubbles SHALL collapse: an empty stage SHALL accept data even when out_ready=0.
REQ-021 in_ready SHALL equal the load condition of stage 1; it is combinational from out_ready and the stage valid bits, with no combinational path from in_valid.
REQ-022 With out_ready held at 1, a result accepted on edge k SHALL present out_valid=1 after edge k+STAGES-1, giving a latency of STAGES cycles and a throughput of 1 per cycle.
REQ-023 While out_valid=1 and out_ready=0, out, carry and ovf SHALL hold stable.
REQ-024 count SHALL equal the number of set stage valid bits, and SHALL be unchanged by a simultaneous input and output transfer.
REQ-025 With all STAGES stages full and out_ready=0, in_ready SHALL be 0; if out_ready rises, in_ready SHALL be 1 in that same cycle.
REQ-026 Results SHALL leave in acceptance order; none SHALL be dropped or duplicated.

Reset
REQ-027 While rst_n=0 at a rising edge, all stage valid bits SHALL clear, so that out_valid=0 and count=0 afterwards.
REQ-028 Reset SHALL zero the out, carry and ovf registers.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight results.
REQ-030 in_ready SHALL be 0 while rst_n=0.
REQ-031 in_ready SHALL be 1 in the first cycle after rst_n returns to 1.

Configuration
REQ-032 With macro PIPE_ADDSUB_SAT_EN defined, the result entering stage 1 SHALL be clamped when ovf=1: to 2^(WIDTH-1)-1 on positive overflow (a sign 0), or to -2^(WIDTH-1) on negative overflow (a sign 1).
REQ-033 With PIPE_ADDSUB_SAT_EN defined, ovf SHALL still report that saturation occurred.
REQ-034 Without PIPE_ADDSUB_SAT_EN, out SHALL be the wrapped modulo-2^WIDTH result and no clamp logic SHALL exist.

Verification (WIDTH=16, STAGES=3)
REQ-035 Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, count=0, in_ready=0; in_ready=1 in the first cycle after release.
REQ-036 Streaming: a=0x0001..0x0005, b=0x0010, sub=0, out_ready=1 -> out 0x0011..0x0015 on consecutive cycles, the first 3 cycles after its acceptance.
REQ-037 Backpressure: out_ready=0 with 4 inputs offered -> 3 accepted, count=3, in_ready=0, out held; raising out_ready drains all results in order with no loss.
REQ-038 Sub and flags: 0x0005-0x0007 -> out 0xFFFE, carry=0, ovf=0; 0xFFFF+0x0001 -> out 0x0000, carry=1, ovf=0.
REQ-039 Overflow: 0x7FFF+0x0001 -> ovf=1, out 0x8000 without the macro and 0x7FFF with PIPE_ADDSUB_SAT_EN; 0x8000-0x0001 -> ovf=1, out 0x7FFF without the macro and 0x8000 with it.
REQ-040 Mid-flight reset: 2 results in flight, rst_n=0 for 1 cycle -> count=0, out_valid=0; no stale result emerges afterwards.
